// File: rtl/uart_tx8.sv
// uart_tx8: 8N1 UART transmitter with a one-byte holding register.
// The host queues a byte while the previous frame is still on the line,
// so consecutive frames go out back-to-back with no idle gap. Bit timing
// comes from a divider on the system clock (CLOCK_RATE / BAUD_RATE).
module uart_tx8 #(
    parameter int CLOCK_RATE = 12000000,
    parameter int BAUD_RATE  = 9600
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       txEn,
    input  logic       txStart,
    input  logic [7:0] txIn,
    output logic       txOut,
    output logic       txReady,
    output logic       txBusy,
    output logic       txDone
);

    localparam int CLKS_PER_BIT = CLOCK_RATE / BAUD_RATE;
    localparam int CNT_W        = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    // A divider below 2 cannot hold a bit for a full baud period.
    if (CLKS_PER_BIT < 2) begin : gBadRate
        $error("uart_tx8: CLOCK_RATE / BAUD_RATE must be at least 2");
    end

    logic [1:0]       state;
    logic [CNT_W-1:0] baudCnt;
    logic [2:0]       bitIdx;
    logic [7:0]       shiftReg;
    logic [7:0]       holdReg;

    logic baudLast;
    logic acceptByte;
    logic frameLoad;
    logic shiftStep;

    assign baudLast   = (baudCnt == LAST_CNT);
    // txReady doubles as "holding register empty", so accept and load can
    // never fire on the same edge: one needs it high, the other low.
    assign acceptByte = txStart && txReady;
    assign frameLoad  = !txReady && txEn &&
                        ((state == IDLE) || ((state == STOP) && baudLast));
    assign shiftStep  = baudLast &&
                        ((state == START) || ((state == DATA) && (bitIdx != 3'd7)));

    // Byte datapath: holding register capture and LSB-first shifter.
    // NOTE: pure data registers carry no reset; the control flags say
    // whether their contents mean anything.
    always_ff @(posedge clk) begin
        if (acceptByte) begin
            holdReg <= txIn;
        end
        if (frameLoad) begin
            shiftReg <= holdReg;
        end else if (shiftStep) begin
            shiftReg <= shiftReg >> 1;
        end
    end

    // Frame control: state, baud/bit counters and registered outputs.
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            baudCnt <= '0;
            bitIdx  <= '0;
            txOut   <= 1'b1;
            txReady <= 1'b1;
            txBusy  <= 1'b0;
            txDone  <= 1'b0;
        end else begin
            txDone <= 1'b0;

            if (acceptByte) begin
                txReady <= 1'b0;
            end else if (frameLoad) begin
                txReady <= 1'b1;
            end

            if (frameLoad) begin
                // Start a frame from IDLE or straight out of the stop bit.
                state   <= START;
                baudCnt <= '0;
                bitIdx  <= '0;
                txOut   <= 1'b0;
                txBusy  <= 1'b1;
                txDone  <= (state == STOP);
            end else begin
                case (state)
                    IDLE: begin
                        txOut   <= 1'b1;
                        txBusy  <= 1'b0;
                        baudCnt <= '0;
                    end
                    START: begin
                        if (baudLast) begin
                            state   <= DATA;
                            baudCnt <= '0;
                            bitIdx  <= '0;
                            txOut   <= shiftReg[0];
                        end else begin
                            baudCnt <= baudCnt + CNT_W'(1);
                        end
                    end
                    DATA: begin
                        if (baudLast) begin
                            baudCnt <= '0;
                            if (bitIdx == 3'd7) begin
                                state <= STOP;
                                txOut <= 1'b1;
                            end else begin
                                bitIdx <= bitIdx + 3'd1;
                                txOut  <= shiftReg[0];
                            end
                        end else begin
                            baudCnt <= baudCnt + CNT_W'(1);
                        end
                    end
                    STOP: begin
                        if (baudLast) begin
                            state   <= IDLE;
                            baudCnt <= '0;
                            txOut   <= 1'b1;
                            txBusy  <= 1'b0;
                            txDone  <= 1'b1;
                        end else begin
                            baudCnt <= baudCnt + CNT_W'(1);
                        end
                    end
                    default: begin
                        state <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_uart_tx8.sv
// tb_uart_tx8: scoreboard bench for uart_tx8. Stimulus pushes each byte it
// expects on the line; a line monitor decodes every frame cycle by cycle
// and compares it with the queued byte and the exact bit timing.
module tb_uart_tx8;

    localparam int D = 16;

    logic       clk = 1'b0;
    logic       rst = 1'b1;

    logic       txEn = 1'b0;
    logic       txStart = 1'b0;
    logic [7:0] txIn = 8'h00;
    logic       txOut, txReady, txBusy, txDone;

    logic       bTxEn = 1'b0;
    logic       bTxStart = 1'b0;
    logic [7:0] bTxIn = 8'h00;
    logic       bTxOut, bTxReady, bTxBusy, bTxDone;

    int         nChecks = 0;
    int         nFails = 0;
    logic [7:0] expQ[$];
    int         frameCount = 0;
    int         doneCount = 0;
    int         busyRun = 0;
    int         lastBusyRun = 0;
    bit         monOff = 1'b0;

    uart_tx8 #(.CLOCK_RATE(160), .BAUD_RATE(10)) dut (
        .clk(clk), .rst(rst), .txEn(txEn), .txStart(txStart), .txIn(txIn),
        .txOut(txOut), .txReady(txReady), .txBusy(txBusy), .txDone(txDone)
    );

    uart_tx8 #(.CLOCK_RATE(2), .BAUD_RATE(1)) dutFast (
        .clk(clk), .rst(rst), .txEn(bTxEn), .txStart(bTxStart), .txIn(bTxIn),
        .txOut(bTxOut), .txReady(bTxReady), .txBusy(bTxBusy), .txDone(bTxDone)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] actual,
                         input logic [31:0] expected);
        nChecks++;
        if (actual !== expected) begin
            nFails++;
            $display("FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Called at a falling edge; returns at the falling edge after acceptance.
    task automatic sendByte(input logic [7:0] b, input bit accepted);
        txIn    = b;
        txStart = 1'b1;
        if (accepted) expQ.push_back(b);
        @(negedge clk);
        txStart = 1'b0;
    endtask

    task automatic waitCycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Busy-run length and txDone pulse count on the main instance.
    always @(negedge clk) begin
        if (txDone === 1'b1) doneCount++;
        if (txBusy === 1'b1) begin
            busyRun++;
        end else begin
            if (busyRun != 0) lastBusyRun = busyRun;
            busyRun = 0;
        end
    end

    // Decode one frame whose start-bit onset is the current falling edge.
    task automatic runFrame();
        logic [7:0] exp;
        logic [7:0] got;
        logic [9:0] pat;
        int         badBits;
        int         busyBad;
        int         doneBad;
        check("frame_expected", (expQ.size() > 0), 1);
        exp = (expQ.size() > 0) ? expQ.pop_front() : 8'h00;
        pat = {1'b1, exp, 1'b0};
        got = 8'h00;
        badBits = 0;
        busyBad = 0;
        doneBad = 0;
        for (int t = 0; t < 10 * D; t++) begin
            if (t > 0) @(negedge clk);
            if (monOff) return;
            if (txOut !== pat[t / D]) badBits++;
            if ((t % D == D / 2) && (t / D >= 1) && (t / D <= 8)) got[t / D - 1] = txOut;
            if (txBusy !== 1'b1) busyBad++;
            if ((t > 0) && (txDone !== 1'b0)) doneBad++;
        end
        @(negedge clk);
        if (monOff) return;
        check("frame_data", got, exp);
        check("frame_bit_timing", badBits, 0);
        check("frame_busy", busyBad, 0);
        check("frame_done_early", doneBad, 0);
        check("frame_done_pulse", txDone, 1'b1);
        frameCount++;
    endtask

    // Line monitor: a low line outside reset marks a start-bit onset.
    initial begin : monitor
        @(negedge clk);
        forever begin
            if (txOut === 1'b0 && !monOff && !rst) runFrame();
            else @(negedge clk);
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation still running, expected finish");
        $fatal(1, "watchdog timeout");
    end

    initial begin : stimulus
        int highs;
        int lows;
        int mism;
        int bLows;
        int bDoneEarly;

        txEn  = 1'b1;
        bTxEn = 1'b1;
        rst   = 1'b1;
        waitCycles(3);
        check("reset_txOut", txOut, 1'b1);
        check("reset_txReady", txReady, 1'b1);
        check("reset_txBusy", txBusy, 1'b0);
        check("reset_txDone", txDone, 1'b0);
        check("reset_fast_txOut", bTxOut, 1'b1);
        check("reset_fast_txReady", bTxReady, 1'b1);
        rst = 1'b0;
        waitCycles(2);

        // Single byte: 0x35 goes out as 1,0,1,0,1,1,0,0 after the start bit.
        sendByte(8'h35, 1'b1);
        check("t1_ready_low", txReady, 1'b0);
        @(negedge clk);
        check("t1_start_txOut", txOut, 1'b0);
        check("t1_start_busy", txBusy, 1'b1);
        check("t1_start_ready", txReady, 1'b1);
        waitCycles(170);
        check("t1_busy_run", lastBusyRun, 160);
        check("t1_frames", frameCount, 1);

        // Back-to-back: second byte queued mid-DATA, third byte dropped.
        sendByte(8'h35, 1'b1);
        waitCycles(40);
        sendByte(8'hA5, 1'b1);
        check("t2_holding_full", txReady, 1'b0);
        sendByte(8'hFF, 1'b0);
        check("t3_still_full", txReady, 1'b0);
        waitCycles(340);
        check("t2_busy_run", lastBusyRun, 320);
        check("t2_idle_after", txBusy, 1'b0);
        check("t3_frames", frameCount, 3);
        check("t3_queue_drained", expQ.size(), 0);

        // Enable gating: a queued byte waits until txEn rises.
        txEn = 1'b0;
        sendByte(8'h5A, 1'b1);
        highs = 0;
        repeat (50) begin
            @(negedge clk);
            if (txOut === 1'b1 && txBusy === 1'b0) highs++;
        end
        check("t4_gated_idle", highs, 50);
        check("t4_gated_ready", txReady, 1'b0);
        txEn = 1'b1;
        @(negedge clk);
        check("t4_start_after_en", txOut, 1'b0);
        check("t4_busy_after_en", txBusy, 1'b1);
        waitCycles(70);
        txEn = 1'b0;
        waitCycles(100);
        check("t4_frame_completes", lastBusyRun, 160);
        check("t4_frames", frameCount, 4);
        txEn = 1'b1;
        waitCycles(5);

        // Same-edge strobe during the transfer is ignored; next one lands.
        sendByte(8'hC3, 1'b1);
        sendByte(8'h3C, 1'b0);
        check("t5_transfer_edge_drop", txReady, 1'b1);
        sendByte(8'h3C, 1'b0);
        check("t5_second_queued", txReady, 1'b0);
        // Reset inside data bit 3 (cycles 64..79 after onset).
        waitCycles(67);
        monOff = 1'b1;
        rst    = 1'b1;
        @(negedge clk);
        check("t5_reset_txOut", txOut, 1'b1);
        check("t5_reset_busy", txBusy, 1'b0);
        check("t5_reset_ready", txReady, 1'b1);
        rst = 1'b0;
        lows = 0;
        repeat (400) begin
            @(negedge clk);
            if (txOut !== 1'b1 || txBusy !== 1'b0) lows++;
        end
        check("t5_no_further_frame", lows, 0);
        check("t5_frames", frameCount, 4);
        monOff = 1'b0;

        // Boundary D=2: byte 0x00 is low 18 cycles, high 2, done at 20.
        bTxIn    = 8'h00;
        bTxStart = 1'b1;
        @(negedge clk);
        bTxStart = 1'b0;
        @(negedge clk);
        mism = 0;
        bLows = 0;
        bDoneEarly = 0;
        for (int t = 0; t < 20; t++) begin
            if (t > 0) @(negedge clk);
            if (bTxOut === 1'b0) bLows++;
            if (bTxOut !== ((t < 18) ? 1'b0 : 1'b1)) mism++;
            if (bTxDone !== 1'b0) bDoneEarly++;
        end
        check("t6_low_cycles", bLows, 18);
        check("t6_pattern", mism, 0);
        check("t6_done_early", bDoneEarly, 0);
        @(negedge clk);
        check("t6_done_pulse", bTxDone, 1'b1);
        check("t6_idle_busy", bTxBusy, 1'b0);
        check("t6_idle_line", bTxOut, 1'b1);

        check("end_queue_empty", expQ.size(), 0);
        check("end_done_count", doneCount, 4);

        $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
        $finish;
    end

endmodule

// File: doc/uart_tx8.md
# uart_tx8

8N1 UART transmitter paired with the existing `Uart8` receive path, driving the serial line from a byte-parallel interface. It has a one-byte holding register so the host can queue the next byte during a frame, giving back-to-back frames with no idle gap. Bit timing comes from an internal divider on the system clock. It uses the same `CLOCK_RATE` convention as the receiver, so both ends run at the same baud.

## Interface
- `CLOCK_RATE`, default 12000000: system clock frequency in Hz.
- `BAUD_RATE`, default 9600: line rate in bit/s.
- Derived `CLKS_PER_BIT` = `CLOCK_RATE / BAUD_RATE`, truncating integer division (1250 at the defaults).
  - Elaboration fails if `CLKS_PER_BIT` < 2.

Ports:
- `clk` in 1: system clock, all logic on rising edge.
- `rst` in 1: reset, synchronous and active-high.
- `txEn` in 1: enable. When low, no new frame starts.
- `txStart` in 1: byte strobe, single cycle, qualified by `txReady`.
- `txIn` in 8: byte to send, sampled with `txStart`.
- `txOut` out 1: serial line, idle high.
- `txReady` out 1: holding register empty, so `txStart` will be accepted.
- `txBusy` out 1: a frame is in progress (start, data or stop bit).
- `txDone` out 1: one-cycle pulse at frame completion.

## Operation
- **Holding register.** If `txStart` and `txReady` are both high at a clock edge, `txIn` is latched and `txReady` goes low. If `txStart` arrives while `txReady` = 0, it is ignored and the byte is dropped; the holding register is unchanged.
- **FSM states:** IDLE, START, DATA, STOP.
- **IDLE.** `txOut` = 1. If the holding register is full and `txEn` = 1, the next edge does all of the following:
  - moves the byte into the shift register;
  - empties the holding register;
  - enters START and drives `txOut` = 0.
- **START.** Held for `CLKS_PER_BIT` cycles, then DATA.
- **DATA.** 8 bits, LSB first, each held `CLKS_PER_BIT` cycles. A 3-bit bit index runs 0..7. After bit 7, go to STOP.
- **STOP.** `txOut` = 1 for `CLKS_PER_BIT` cycles. At the end of the stop bit, `txDone` pulses for 1 cycle, then:
  - if the holding register is full and `txEn` = 1: go directly to START, loading the shifter the same edge. There is no idle cycle between the stop bit and the next start bit.
  - otherwise go to IDLE.
- **Baud counter.** Counts 0..`CLKS_PER_BIT`-1 and resets to 0 on every state entry. The counter width is clog2(`CLKS_PER_BIT`).
- **`txEn` low mid-frame.** The current frame completes unchanged. A queued byte stays held until `txEn` returns high.
- **`txBusy`** is 1 in START, DATA and STOP, and 0 in IDLE.
- **Simultaneous events.** A `txStart` in the same cycle the holding register transfers to the shifter is not accepted, because `txReady` is still 0 that cycle. It is accepted one cycle later.
- **`rst`** takes priority at any point, including mid-frame. On the next edge:
  - FSM to IDLE;
  - `txOut` = 1;
  - holding register emptied;
  - counters cleared;
  - pending byte discarded.

## Timing
- Reset values: `txOut` = 1, `txReady` = 1, `txBusy` = 0, `txDone` = 0.
- All outputs are registered.
- `txStart` accepted at edge N: `txReady` = 0 and holding full after edge N. If IDLE and `txEn` = 1, after edge N+1:
  - `txOut` = 0 (start bit);
  - `txBusy` = 1;
  - `txReady` = 1.
- Frame length: exactly 10 × `CLKS_PER_BIT` cycles from the first start-bit cycle to the last stop-bit cycle.
- Data bit k occupies cycles [(1+k)·D, (2+k)·D) relative to the start-bit onset, where D = `CLKS_PER_BIT`.
- `txDone` is high in the first cycle after the stop bit, i.e. cycle 10·D:
  - if idle follows: `txBusy` = 0 in that cycle;
  - if back-to-back: the next start bit begins in that same cycle.
- Bench bit-timing checks allow no cycle of tolerance.

## Test plan
Use bench parameters `CLOCK_RATE`=160, `BAUD_RATE`=10, giving D=16.

1. **Single byte.** After reset, `txEn`=1, `txStart` with `txIn`=8'b00110101.
   - `txOut` low 16 cycles, then 1,0,1,0,1,1,0,0 at 16 cycles each, then high 16 cycles.
   - `txDone` pulses once at cycle 160 after start onset.
   - A loopback `Uart8` rx at the same `CLOCK_RATE` (default parameters) reports `rxOut`=8'h35 with `rxErr`=0.
2. **Back-to-back.** Queue 8'h35 and 8'hA5 (second `txStart` while the first is in DATA).
   - The second start bit follows the first stop bit with zero idle cycles.
   - 320 cycles total, `txBusy` continuously high.
3. **Dropped byte.** With the holding register full, pulse `txStart` with 8'hFF.
   - Ignored; the transmitted sequence contains only the earlier bytes.
4. **Enable gating.**
   - `txEn`=0 with a byte queued: `txOut` stays 1 and `txReady`=0 indefinitely.
   - Raise `txEn`: start bit 1 cycle later.
   - Drop `txEn` mid-DATA: the frame still completes all 10 bits.
5. **Reset mid-frame.** Assert `rst` during data bit 3 with a second byte queued.
   - Next cycle: `txOut`=1, `txBusy`=0, `txReady`=1.
   - No further frame transmitted.
6. **Boundary.** `CLOCK_RATE`=2, `BAUD_RATE`=1 (D=2).
   - Byte 8'h00 gives `txOut` low for exactly 18 cycles, then high for 2.
   - `txDone` at cycle 20.
